// File: rtl/coord_readout_pkg.sv
// Shared definitions for the coordinate readout controller.
//   - FSM state encoding
//   - ASCII character constants and digit formatting helpers
//   - double-dabble iteration count and BCD vector type
package coord_readout_pkg;

    localparam int COORD_W    = 10;
    localparam int NUM_DIGITS = 3;
    localparam int NUM_ITER   = COORD_W;
    localparam int ITER_W     = 4;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NINE  = ASCII_ZERO + 8'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_X,
        ST_CONV_Y,
        ST_COMMIT
    } state_e;

    // Four BCD nibbles: [3]=thousands .. [0]=ones
    typedef logic [3:0][3:0] bcd4_t;

    typedef logic [8*NUM_DIGITS-1:0] chars_t;

    // A nonzero thousands digit means the value cannot be shown in three digits.
    function automatic logic bcd_overflow(input bcd4_t b);
        return (b[3] != 4'd0);
    endfunction

    // Packs {hundreds, tens, ones} ASCII codes; saturates to "999" on overflow.
    function automatic chars_t bcd_to_chars(input bcd4_t b);
        chars_t c;
        c = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_overflow(b)) begin
                c[8*d +: 8] = ASCII_NINE;
            end else begin
                c[8*d +: 8] = ASCII_ZERO + {4'h0, b[d]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/coord_readout_ctrl_if.sv
// Bus bundle between the readout controller and its user (video pipeline).
//   master: frame timing + coordinates + font lookup request; reads results
//   slave : the controller; drives characters, font address and status
interface coord_readout_ctrl_if;
    import coord_readout_pkg::*;

    logic                 frame_start;
    logic [COORD_W-1:0]   x_coordinate;
    logic [COORD_W-1:0]   y_coordinate;
    logic [2:0]           char_sel;
    logic [3:0]           font_row;
    logic [10:0]          font_addr;
    chars_t               x_chars;
    chars_t               y_chars;
    logic                 busy;
    logic                 done;
    logic [1:0]           sat;
    logic                 missed;

    modport master (
        output frame_start, x_coordinate, y_coordinate, char_sel, font_row,
        input  font_addr, x_chars, y_chars, busy, done, sat, missed
    );

    modport slave (
        input  frame_start, x_coordinate, y_coordinate, char_sel, font_row,
        output font_addr, x_chars, y_chars, busy, done, sat, missed
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD engine, one iteration per step.
//   Clk, Reset : clock, synchronous active-high reset
//   load       : clear BCD accumulator and capture value (wins over step)
//   value      : binary value to convert
//   step       : perform one add-3-then-shift iteration
//   bcd        : BCD accumulator; while step is high it shows the post-step
//                value so the final iteration can be captured on the same edge
module bin2bcd_seq
    import coord_readout_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [COORD_W-1:0] value,
    input  logic               step,
    output bcd4_t              bcd
);

    logic [COORD_W-1:0] r_bin;
    bcd4_t              r_bcd;
    bcd4_t              w_adj;
    logic [15:0]        w_adj_flat;
    bcd4_t              w_stepped;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign w_adj[gi] = (r_bcd[gi] >= 4'd5) ? r_bcd[gi] + 4'd3 : r_bcd[gi];
        end
    endgenerate

    assign w_adj_flat = w_adj;
    assign w_stepped  = {w_adj_flat[14:0], r_bin[COORD_W-1]};
    assign bcd        = step ? w_stepped : r_bcd;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin <= '0;
            r_bcd <= '0;
        end else if (load) begin
            r_bin <= value;
            r_bcd <= '0;
        end else if (step) begin
            r_bin <= {r_bin[COORD_W-2:0], 1'b0};
            r_bcd <= w_stepped;
        end
    end

endmodule

// File: rtl/coord_readout_ctrl.sv
// Coordinate readout controller: on each frame start, snapshots X/Y, converts
// them to decimal on one shared BCD engine (X then Y), and commits six ASCII
// codes at once. Also provides a registered font ROM address lookup.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of coord_readout_ctrl_if (frame_start, coordinates,
//                char_sel/font_row in; font_addr, x/y_chars, busy, done, sat,
//                missed out)
module coord_readout_ctrl
    import coord_readout_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    coord_readout_ctrl_if.slave bus
);

    state_e             r_state;
    state_e             w_state_next;
    logic [ITER_W-1:0]  r_iter;
    logic               w_last_iter;

    logic               w_load;
    logic               w_step;
    logic [COORD_W-1:0] w_load_value;
    logic               w_latch_x;
    logic               w_commit;
    bcd4_t              w_bcd;

    // The engine's binary register serves as the X snapshot; Y waits here.
    logic [COORD_W-1:0] r_snap_y;
    bcd4_t              r_x_bcd;
    chars_t             r_x_chars;
    chars_t             r_y_chars;
    logic [1:0]         r_sat;
    logic               r_done;
    logic               r_missed;
    logic [10:0]        r_font_addr;

    logic [6:0]         w_slot [8];
    logic [6:0]         w_code7;

    bin2bcd_seq u_bin2bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (w_load),
        .value (w_load_value),
        .step  (w_step),
        .bcd   (w_bcd)
    );

    assign w_last_iter = (r_iter == ITER_W'(NUM_ITER - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_load_value = bus.x_coordinate;
        w_latch_x    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_CONV_X;
                end
            end
            ST_CONV_X: begin
                w_step = 1'b1;
                if (w_last_iter) begin
                    // Last X iteration: capture post-step BCD and reload with Y together.
                    w_latch_x    = 1'b1;
                    w_load       = 1'b1;
                    w_load_value = r_snap_y;
                    w_state_next = ST_CONV_Y;
                end
            end
            ST_CONV_Y: begin
                w_step = 1'b1;
                if (w_last_iter) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_iter    <= '0;
            r_snap_y  <= '0;
            r_x_bcd   <= '0;
            r_x_chars <= {NUM_DIGITS{ASCII_ZERO}};
            r_y_chars <= {NUM_DIGITS{ASCII_ZERO}};
            r_sat     <= 2'b00;
            r_done    <= 1'b0;
            r_missed  <= 1'b0;
        end else begin
            if (w_step && !w_last_iter) begin
                r_iter <= r_iter + 1'b1;
            end else begin
                r_iter <= '0;
            end
            if (r_state == ST_IDLE && bus.frame_start) begin
                r_snap_y <= bus.y_coordinate;
            end
            if (r_state != ST_IDLE && bus.frame_start) begin
                r_missed <= 1'b1;
            end
            if (w_latch_x) begin
                r_x_bcd <= w_bcd;
            end
            // Engine is idle in COMMIT, so w_bcd is the finished Y result.
            if (w_commit) begin
                r_x_chars <= bcd_to_chars(r_x_bcd);
                r_y_chars <= bcd_to_chars(w_bcd);
                r_sat     <= {bcd_overflow(w_bcd), bcd_overflow(r_x_bcd)};
            end
            r_done <= w_commit;
        end
    end

    // Character slot table; ASCII codes fit in 7 bits for the font ROM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slots
            assign w_slot[gi]              = r_x_chars[8*(NUM_DIGITS-1-gi) +: 7];
            assign w_slot[gi + NUM_DIGITS] = r_y_chars[8*(NUM_DIGITS-1-gi) +: 7];
        end
        for (gi = 2*NUM_DIGITS; gi < 8; gi++) begin : g_blank
            assign w_slot[gi] = ASCII_SPACE[6:0];
        end
    endgenerate

    assign w_code7 = w_slot[bus.char_sel];

    // Reads committed registers, so a lookup on the commit edge sees old text.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_font_addr <= '0;
        end else begin
            r_font_addr <= {w_code7, bus.font_row};
        end
    end

    assign bus.font_addr = r_font_addr;
    assign bus.x_chars   = r_x_chars;
    assign bus.y_chars   = r_y_chars;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.sat       = r_sat;
    assign bus.missed    = r_missed;

endmodule

// File: tb/tb_coord_readout_ctrl.sv
module tb_coord_readout_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference state: what the display should currently show.
    logic [23:0] m_x_chars;
    logic [23:0] m_y_chars;
    logic [1:0]  m_sat;

    coord_readout_ctrl_if ifc ();

    coord_readout_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal text of a coordinate: {sat, hundreds, tens, ones}
    function automatic logic [24:0] ref_text(input int v);
        logic [24:0] r;
        if (v > 999) begin
            r = {1'b1, 24'h393939};
        end else begin
            r[24]    = 1'b0;
            r[23:16] = 8'(8'h30 + v / 100);
            r[15:8]  = 8'(8'h30 + (v / 10) % 10);
            r[7:0]   = 8'(8'h30 + v % 10);
        end
        return r;
    endfunction

    function automatic logic [10:0] ref_font(input int sel, input logic [3:0] row,
                                             input logic [23:0] xc, input logic [23:0] yc);
        logic [7:0] code;
        if (sel < 3)      code = xc[8*(2-sel) +: 8];
        else if (sel < 6) code = yc[8*(5-sel) +: 8];
        else              code = 8'h20;
        return {code[6:0], row};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_x_chars = 24'h303030;
        m_y_chars = 24'h303030;
        m_sat     = 2'b00;
    endtask

    // One conversion; optionally a second frame_start with a new x at tick dup_at.
    task automatic convert(input int x, input int y, input int dup_at, input int new_x);
        int first_done;
        int dones;
        int busy_cnt;
        logic [24:0] ex;
        logic [24:0] ey;
        logic [10:0] pre_font;
        ifc.x_coordinate = 10'(x);
        ifc.y_coordinate = 10'(y);
        ifc.char_sel     = 3'd2;
        ifc.font_row     = 4'h5;
        pre_font = ref_font(2, 4'h5, m_x_chars, m_y_chars);
        ifc.frame_start  = 1'b1;
        first_done = 0;
        dones      = 0;
        busy_cnt   = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            ifc.frame_start = 1'b0;
            if (dup_at != 0 && n == dup_at) begin
                ifc.frame_start  = 1'b1;
                ifc.x_coordinate = 10'(new_x);
            end
            if (ifc.busy === 1'b1) busy_cnt++;
            if (ifc.done === 1'b1) begin
                dones++;
                if (first_done == 0) begin
                    first_done = n;
                    check("font_at_commit", 32'(ifc.font_addr), 32'(pre_font));
                end
            end
        end
        ex = ref_text(x);
        ey = ref_text(y);
        m_x_chars = ex[23:0];
        m_y_chars = ey[23:0];
        m_sat     = {ey[24], ex[24]};
        check("done_latency", 32'(first_done), 32'd22);
        check("done_count", 32'(dones), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'd21);
        check("x_chars", 32'(ifc.x_chars), 32'(m_x_chars));
        check("y_chars", 32'(ifc.y_chars), 32'(m_y_chars));
        check("sat", 32'(ifc.sat), 32'(m_sat));
        check("font_after_commit", 32'(ifc.font_addr), 32'(ref_font(2, 4'h5, m_x_chars, m_y_chars)));
        $display("conv x=%0d y=%0d x_chars=%h y_chars=%h sat=%b latency=%0d",
                 x, y, ifc.x_chars, ifc.y_chars, ifc.sat, first_done);
    endtask

    initial begin
        int dones;
        logic [3:0] row;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.frame_start  = 1'b0;
        ifc.x_coordinate = '0;
        ifc.y_coordinate = '0;
        ifc.char_sel     = 3'd0;
        ifc.font_row     = 4'h0;
        do_reset();

        check("rst_x_chars", 32'(ifc.x_chars), 32'h303030);
        check("rst_y_chars", 32'(ifc.y_chars), 32'h303030);
        check("rst_font_addr", 32'(ifc.font_addr), 32'h0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_sat", 32'(ifc.sat), 32'd0);
        check("rst_missed", 32'(ifc.missed), 32'd0);

        convert(0, 0, 0, 0);
        convert(637, 479, 0, 0);

        // Font lookup against the committed 637 text
        ifc.char_sel = 3'd1;
        ifc.font_row = 4'hA;
        tick();
        check("font_sel1", 32'(ifc.font_addr), 32'h33A);
        ifc.char_sel = 3'd7;
        tick();
        check("font_sel7", 32'(ifc.font_addr), 32'h20A);
        for (int s = 0; s < 8; s++) begin
            row = 4'($urandom_range(0, 15));
            ifc.char_sel = 3'(s);
            ifc.font_row = row;
            tick();
            check($sformatf("font_sel%0d", s), 32'(ifc.font_addr),
                  32'(ref_font(s, row, m_x_chars, m_y_chars)));
        end

        convert(1023, 999, 0, 0);
        convert(1000, 1001, 0, 0);
        check("missed_before", 32'(ifc.missed), 32'd0);

        // Overlapping frame_start with changed x: ignored, flagged, x=250 kept
        convert(250, 38, 5, 5);
        check("missed_after", 32'(ifc.missed), 32'd1);

        for (int k = 0; k < 6; k++) begin
            convert(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0);
        end

        // Reset mid-conversion: nothing committed, no done
        ifc.x_coordinate = 10'd123;
        ifc.y_coordinate = 10'd456;
        ifc.frame_start  = 1'b1;
        dones = 0;
        for (int n = 1; n <= 35; n++) begin
            tick();
            ifc.frame_start = 1'b0;
            rst = (n == 12);
            if (ifc.done === 1'b1) dones++;
        end
        m_x_chars = 24'h303030;
        m_y_chars = 24'h303030;
        m_sat     = 2'b00;
        check("abort_done_count", 32'(dones), 32'd0);
        check("abort_x_chars", 32'(ifc.x_chars), 32'h303030);
        check("abort_y_chars", 32'(ifc.y_chars), 32'h303030);
        check("abort_busy", 32'(ifc.busy), 32'd0);
        check("abort_missed", 32'(ifc.missed), 32'd0);
        $display("abort x=123 at cycle 12 dones=%0d x_chars=%h", dones, ifc.x_chars);

        convert(123, 456, 0, 0);
        check("x_123", 32'(ifc.x_chars), 32'h313233);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
